// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter/sequencer for a single-port
// synchronous RAM with registered dataout.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_x, we_x, lock_x         per-port request, write enable, lock (x = a, b)
//   addr_x, wdata_x             per-port address and write data
//   gnt_x                       one-cycle grant pulse
//   rvalid_x, rdata_x           one-cycle completion strobe and data
//   busy                        high while an access is in flight
//   ram_rw, ram_addr, ram_wdata RAM control/address/write data (registered)
//   ram_rdata                   RAM registered dataout
module ram_arbiter #(
  parameter int unsigned data_width = 4,
  parameter int unsigned addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic                  lock_a,
  input  logic                  lock_b,
  input  logic [addr_width-1:0] addr_a,
  input  logic [addr_width-1:0] addr_b,
  input  logic [data_width-1:0] wdata_a,
  input  logic [data_width-1:0] wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [data_width-1:0] rdata_a,
  output logic [data_width-1:0] rdata_b,
  output logic                  busy,
  output logic                  ram_rw,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_wdata,
  input  logic [data_width-1:0] ram_rdata
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t                state_q;
  logic                  owner_q;
  logic                  last_q;
  logic                  locked_q;
  logic                  gnt_a_q;
  logic                  gnt_b_q;
  logic                  rvalid_a_q;
  logic                  rvalid_b_q;
  logic                  busy_q;
  logic                  ram_rw_q;
  logic [addr_width-1:0] ram_addr_q;
  logic [data_width-1:0] ram_wdata_q;

  logic                  owner_req_c;
  logic                  win_valid_c;
  logic                  win_b_c;
  logic                  win_we_c;
  logic                  win_lock_c;
  logic [addr_width-1:0] win_addr_c;
  logic [data_width-1:0] win_wdata_c;

  // Winner selection: a held lock beats round-robin; a tie goes to the port
  // that was not served last.
  always_comb begin
    win_valid_c = 1'b0;
    win_b_c     = PORT_A;
    owner_req_c = (owner_q == PORT_B) ? req_b : req_a;
    if (locked_q && owner_req_c) begin
      win_valid_c = 1'b1;
      win_b_c     = owner_q;
    end else if (req_a && req_b) begin
      win_valid_c = 1'b1;
      win_b_c     = (last_q == PORT_A) ? PORT_B : PORT_A;
    end else if (req_a) begin
      win_valid_c = 1'b1;
      win_b_c     = PORT_A;
    end else if (req_b) begin
      win_valid_c = 1'b1;
      win_b_c     = PORT_B;
    end
  end

  // Winner's request fields.
  always_comb begin
    win_we_c    = win_b_c ? we_b    : we_a;
    win_lock_c  = win_b_c ? lock_b  : lock_a;
    win_addr_c  = win_b_c ? addr_b  : addr_a;
    win_wdata_c = win_b_c ? wdata_b : wdata_a;
  end

  // Sequencer: IDLE grants and launches, ACCESS completes and returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= PORT_A;
      last_q      <= PORT_B;
      locked_q    <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      busy_q      <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid_c) begin
            ram_addr_q  <= win_addr_c;
            ram_wdata_q <= win_wdata_c;
            ram_rw_q    <= win_we_c;
            gnt_a_q     <= ~win_b_c;
            gnt_b_q     <= win_b_c;
            owner_q     <= win_b_c;
            locked_q    <= win_lock_c;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end else begin
            // Nobody requesting means a held lock's owner walked away.
            ram_rw_q <= 1'b0;
            locked_q <= 1'b0;
          end
        end
        ACCESS: begin
          ram_rw_q   <= 1'b0;
          rvalid_a_q <= ~owner_q;
          rvalid_b_q <= owner_q;
          last_q     <= owner_q;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign rvalid_a  = rvalid_a_q;
  assign rvalid_b  = rvalid_b_q;
  assign busy      = busy_q;
  assign ram_rw    = ram_rw_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // RAM dataout is registered and echoes datain on writes, so it is the
  // completion data for both reads and writes.
  assign rdata_a = ram_rdata;
  assign rdata_b = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed testbench for ram_arbiter with a behavioural
// single-port RAM (registered dataout, write echoes datain).
module tb_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b, we_a, we_b, lock_a, lock_b;
  logic [3:0] addr_a, addr_b, wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_rw;
  logic [3:0] rdata_a, rdata_b, ram_addr, ram_wdata, ram_rdata;

  logic [3:0] mem [16];
  int         vectors;
  int         miscompares;

  ram_arbiter #(.data_width(4), .addr_width(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .lock_a(lock_a), .lock_b(lock_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model.
  always @(posedge clk) begin
    if (ram_rw) begin
      mem[ram_addr] <= ram_wdata;
      ram_rdata     <= ram_wdata;
    end else begin
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0; lock_a = 0; lock_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 0;
    #1;
    vectors++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_rw, ram_addr, ram_wdata} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_rw, ram_addr, ram_wdata});
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_write_read_a();
    do_reset();
    req_a = 1; we_a = 1; addr_a = 4'd3; wdata_a = 4'hA;
    tick();  // E0
    vectors++;
    if ({gnt_a, gnt_b, ram_rw, busy, ram_addr, ram_wdata} !== {4'b1011, 4'd3, 4'hA}) begin
      miscompares++;
      $display("FAIL wr_a_grant: got %b expected %b",
               {gnt_a, gnt_b, ram_rw, busy, ram_addr, ram_wdata}, {4'b1011, 4'd3, 4'hA});
    end
    req_a = 0;
    tick();  // E1
    vectors++;
    if ({rvalid_a, rvalid_b, ram_rw, busy, gnt_a, rdata_a} !== {5'b10000, 4'hA}) begin
      miscompares++;
      $display("FAIL wr_a_complete: got %b expected %b",
               {rvalid_a, rvalid_b, ram_rw, busy, gnt_a, rdata_a}, {5'b10000, 4'hA});
    end
    req_a = 1; we_a = 0; addr_a = 4'd3;
    tick();  // E2
    vectors++;
    if ({gnt_a, ram_rw, busy} !== 3'b101) begin
      miscompares++;
      $display("FAIL rd_a_grant: got %b expected 101", {gnt_a, ram_rw, busy});
    end
    req_a = 0;
    tick();  // E3
    vectors++;
    if ({rvalid_a, rdata_a} !== {1'b1, 4'hA}) begin
      miscompares++;
      $display("FAIL rd_a_data: got %b expected %b", {rvalid_a, rdata_a}, {1'b1, 4'hA});
    end
  endtask

  task automatic test_simultaneous();
    // Expected {gnt_a, gnt_b, rvalid_a, rvalid_b} after each edge.
    logic [3:0] exp_seq [8];
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100; exp_seq[3] = 4'b0001;
    exp_seq[4] = 4'b1000; exp_seq[5] = 4'b0010;
    exp_seq[6] = 4'b0100; exp_seq[7] = 4'b0001;
    do_reset();
    req_a = 1; addr_a = 4'd1; req_b = 1; addr_b = 4'd4;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if ({gnt_a, gnt_b, rvalid_a, rvalid_b} !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL rr_strobes[%0d]: got %b expected %b", i,
                 {gnt_a, gnt_b, rvalid_a, rvalid_b}, exp_seq[i]);
      end
      if (rvalid_a || rvalid_b) begin
        vectors++;
        if (ram_rdata !== 4'h0) begin
          miscompares++;
          $display("FAIL rr_rdata[%0d]: got %h expected 0", i, ram_rdata);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    req_b = 1; we_b = 0; addr_b = 4'd5; lock_b = 1;
    tick();  // E0
    vectors++;
    if ({gnt_a, gnt_b} !== 2'b01) begin
      miscompares++;
      $display("FAIL lock_first_gnt: got %b expected 01", {gnt_a, gnt_b});
    end
    we_b = 1; wdata_b = 4'h7; lock_b = 0;
    req_a = 1; we_a = 0; addr_a = 4'd5;
    tick();  // E1
    vectors++;
    if ({rvalid_b, rdata_b} !== {1'b1, 4'h0}) begin
      miscompares++;
      $display("FAIL lock_first_data: got %b expected %b", {rvalid_b, rdata_b}, {1'b1, 4'h0});
    end
    tick();  // E2: lock holds B despite the tie
    vectors++;
    if ({gnt_a, gnt_b, ram_rw, ram_wdata} !== {3'b011, 4'h7}) begin
      miscompares++;
      $display("FAIL lock_second_gnt: got %b expected %b",
               {gnt_a, gnt_b, ram_rw, ram_wdata}, {3'b011, 4'h7});
    end
    req_b = 0; we_b = 0;
    tick();  // E3
    vectors++;
    if ({rvalid_b, ram_rw, rdata_b} !== {2'b10, 4'h7}) begin
      miscompares++;
      $display("FAIL lock_second_data: got %b expected %b",
               {rvalid_b, ram_rw, rdata_b}, {2'b10, 4'h7});
    end
    tick();  // E4
    vectors++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      miscompares++;
      $display("FAIL lock_then_a: got %b expected 10", {gnt_a, gnt_b});
    end
    req_a = 0;
    tick();  // E5
    vectors++;
    if ({rvalid_a, rdata_a} !== {1'b1, 4'h7}) begin
      miscompares++;
      $display("FAIL lock_a_read: got %b expected %b", {rvalid_a, rdata_a}, {1'b1, 4'h7});
    end
  endtask

  task automatic test_lock_release();
    do_reset();
    req_b = 1; addr_b = 4'd0; lock_b = 1;
    tick();  // E0
    vectors++;
    if (gnt_b !== 1'b1) begin
      miscompares++;
      $display("FAIL rel_gnt_b: got %b expected 1", gnt_b);
    end
    req_b = 0; lock_b = 0;
    req_a = 1; addr_a = 4'd3;
    tick();  // E1
    tick();  // E2
    vectors++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      miscompares++;
      $display("FAIL rel_gnt_a: got %b expected 10", {gnt_a, gnt_b});
    end
    req_a = 0;
    tick();  // E3
    vectors++;
    if ({rvalid_a, rdata_a} !== {1'b1, 4'hA}) begin
      miscompares++;
      $display("FAIL rel_a_data: got %b expected %b", {rvalid_a, rdata_a}, {1'b1, 4'hA});
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    req_a = 1; we_a = 1; addr_a = 4'd2; wdata_a = 4'hF;
    tick();  // E0
    vectors++;
    if ({gnt_a, ram_rw} !== 2'b11) begin
      miscompares++;
      $display("FAIL midrst_gnt: got %b expected 11", {gnt_a, ram_rw});
    end
    #2;
    rst_n = 0;
    #1;
    vectors++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_rw, ram_addr, ram_wdata} !== 14'h0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got %b expected all zero",
               {gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_rw, ram_addr, ram_wdata});
    end
    idle_inputs();
    tick();  // E1 under reset
    vectors++;
    if ({rvalid_a, rvalid_b} !== 2'b00) begin
      miscompares++;
      $display("FAIL midrst_rvalid: got %b expected 00", {rvalid_a, rvalid_b});
    end
    @(negedge clk);
    rst_n = 1;
    req_a = 1; we_a = 0; addr_a = 4'd2;
    tick();
    req_a = 0;
    tick();
    vectors++;
    if ({rvalid_a, rdata_a} !== {1'b1, 4'h0}) begin
      miscompares++;
      $display("FAIL midrst_readback: got %b expected %b", {rvalid_a, rdata_a}, {1'b1, 4'h0});
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({ram_rw, busy, gnt_a, gnt_b, rvalid_a, rvalid_b} !== 6'b0) begin
        miscompares++;
        $display("FAIL idle[%0d]: got %b expected 000000", i,
                 {ram_rw, busy, gnt_a, gnt_b, rvalid_a, rvalid_b});
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 0;
    idle_inputs();
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    test_reset();
    test_write_read_a();
    test_simultaneous();
    test_lock();
    test_lock_release();
    test_reset_mid_write();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the single-port synchronous RAM. Port A (instruction fetch) and port B (load/store unit) each issue read or write requests. The block grants one at a time, drives the RAM's `rw/addr/datain`, and returns the RAM's registered `dataout` to the winner with a valid strobe. It guarantees that the RAM sees a write strobe for exactly one clock per granted write and reads at all other times.

## Interface
- `data_width`, 4: RAM word width.
- `addr_width`, 4: RAM address width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_a`, `req_b` in 1: access request per port.
- `we_a`, `we_b` in 1: 1 = write, 0 = read. Qualified by `req_x`.
- `lock_a`, `lock_b` in 1: with request, keep the port for its next access (read-modify-write).
- `addr_a`, `addr_b` in addr_width: access address.
- `wdata_a`, `wdata_b` in data_width: write data.
- `gnt_a`, `gnt_b` out 1: one-cycle grant pulse (request accepted).
- `rvalid_a`, `rvalid_b` out 1: one-cycle completion strobe.
- `rdata_a`, `rdata_b` out data_width: completion data, valid only with `rvalid_x`.
- `busy` out 1: high while state ≠ IDLE.
- `ram_rw` out 1: to RAM `rw` (1 = write, 0 = read).
- `ram_addr` out addr_width: to RAM `addr`.
- `ram_wdata` out data_width: to RAM `datain`.
- `ram_rdata` in data_width: from RAM `dataout`.

## Operation
- FSM has two states, IDLE and ACCESS. The reset state is IDLE.
- **IDLE**, at a clock edge with any eligible request:
  - Choose a winner.
  - Register `ram_addr`, `ram_wdata` and `ram_rw` from the winner's `we`.
  - Pulse `gnt_winner`.
  - Latch `owner` and the winner's `lock` into `locked`.
  - Go to ACCESS.
- **IDLE** with no eligible request: stay in IDLE, `ram_rw` = 0.
- **ACCESS**, next edge:
  - Clear `ram_rw` to 0.
  - Pulse `rvalid_owner`.
  - Update `last` to `owner`.
  - Go to IDLE.
  - Requests are ignored in ACCESS.
- `rdata_x` = `ram_rdata` (combinational pass-through). It is meaningful only while `rvalid_x` = 1.
  - Reads: RAM contents at `addr`.
  - Writes: the written data, because the RAM echoes `datain`.
- Arbitration, evaluated in order:
  - If `locked` = 1 and the owner requests: the owner wins and the other port waits.
  - If `locked` = 1 and the owner does not request: the lock drops and normal arbitration applies in the same cycle.
  - If only one port requests, it wins.
  - If both request, the port ≠ `last` wins.
  - `last` resets to B, so A wins the first tie.
- Requester rules:
  - Hold `req/we/addr/wdata/lock` stable until `gnt_x` is seen.
  - Drop `req` in the cycle `gnt_x` is high unless another access is wanted.
  - `req` still high at the following IDLE edge counts as a new request.
- `ram_addr` and `ram_wdata` hold their last values while idle. Only `ram_rw` gates writes.

## Timing
- Edge E0 (IDLE, request sampled): `gnt_x` = 1, `ram_*` valid, `busy` = 1, for the cycle E0–E1.
- Edge E1: RAM samples. `rvalid_x` = 1 and `rdata_x` is valid for the cycle E1–E2. State returns to IDLE and `busy` = 0.
- Next grant no earlier than E2. Maximum throughput is one access per 2 cycles.
- Latency from request sampled to data: 2 edges.
- `gnt_a`, `gnt_b`, `rvalid_a`, `rvalid_b` are never high simultaneously with the other port's same-type strobe.
- `ram_rw` is high for at most one cycle per granted write.
- Reset (`rst_n` low, any time, including mid-ACCESS):
  - State = IDLE.
  - All `gnt`, `rvalid`, `busy`, `ram_rw`, `ram_addr`, `ram_wdata` = 0.
  - `locked` = 0, `last` = B.
  - An in-flight access is abandoned with no `rvalid`.
  - A write granted at E0 with reset asserted before E1 must not reach the RAM.
- Reset release: the first arbitration happens at the first rising edge with `rst_n` high.

## Test plan
- **Single write then read, port A.** Write addr 3 / data 0xA, then read addr 3.
  - Write: `gnt_a` at E0, `ram_rw` = 1 for exactly one cycle, `rvalid_a` with `rdata_a` = 0xA.
  - Read: `rdata_a` = 0xA, 2 edges after request.
- **Simultaneous requests from reset.** Both ports read continuously.
  - Grants alternate A, B, A, B.
  - A read of addr 1 returns 0 (cleared RAM).
  - No overlapping strobes.
- **Lock.** Port B issues a read of addr 5 with `lock_b` = 1, then a write of 0x7 to addr 5, while A requests throughout.
  - B gets both accesses back-to-back (grants 2 cycles apart), then A is granted.
  - A's read of addr 5 returns 0x7.
- **Lock release.** B is granted with `lock_b` = 1, then drops `req_b`.
  - A is granted at the next IDLE edge.
- **Reset mid-write.** A requests a write of 0xF to addr 2; `rst_n` is pulled low after E0 and before E1.
  - All outputs read 0 immediately.
  - No `rvalid`.
  - A later read of addr 2 returns 0.
- **Idle safety.** No requests for 10 cycles.
  - `ram_rw` stays 0, `busy` = 0, no strobes.
